// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller.
// Moore-decoded controls, retired-instruction counter.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ExtOp,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [1:0]       PCSource,
  output logic             PCWr,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ORIEX  = 4'd9;
  localparam logic [3:0] S_ORIWB  = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;

  logic [3:0] st;
  logic [3:0] nxt;
  logic       retire;

  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  nxt = S_MEMADR;
          (op == OP_R):   nxt = S_EXEC;
          (op == OP_ORI): nxt = S_ORIEX;
          (op == OP_BEQ): nxt = S_BRANCH;
          (op == OP_J):   nxt = S_JUMP;
          default:        nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXEC: begin
        if (funct == F_ADDU || funct == F_SUBU)
          nxt = S_RWB;
      end
      S_ORIEX:  nxt = S_ORIWB;
      default:  nxt = S_FETCH;
    endcase
  end

  assign retire = (st == S_MEMWB) || (st == S_MEMWR) ||
                  (st == S_RWB) || (st == S_BRANCH) ||
                  (st == S_ORIWB) || (st == S_JUMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_FETCH;
      instr_cnt <= '0;
    end else begin
      st <= nxt;
      if (retire)
        instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset masks every control, even before the first edge.
  assign state = rst ? S_FETCH : st;

  always_comb begin
    ALUOp    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ExtOp    = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    PCSource = 2'b00;
    PCWr     = 1'b0;
    if (!rst) begin
      case (st)
        S_FETCH: begin
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWr    = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          ExtOp   = 1'b1;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ExtOp   = 1'b1;
        end
        S_MEMRD: IorD = 1'b1;
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = (funct == F_SUBU) ? 2'b01 : 2'b00;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          PCWr     = zero;
        end
        S_ORIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
        end
        S_ORIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCWr     = 1'b1;
          PCSource = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table vectors, corner sequences and
// randomized instruction stream against a path model.
module tb_mc_ctrl;

  typedef struct packed {
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       ext;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic [1:0] pcs;
    logic       pcw;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    int         inc;
  } tv_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, ORI = 6'b001101;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic zero = 1'b0;

  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic ALUSrcA, ExtOp, IorD, MemWrite, IRWrite;
  logic RegWrite, RegDst, MemtoReg, PCWr;
  logic [3:0] state;
  logic [31:0] instr_cnt;

  logic [1:0] a4, b4, p4;
  logic s4, e4, i4, m4, ir4, r4, d4, t4, w4;
  logic [3:0] st4;
  logic [3:0] cnt4;

  ctl_t act;
  assign act = {ALUOp, ALUSrcA, ALUSrcB, ExtOp, IorD,
                MemWrite, IRWrite, RegWrite, RegDst,
                MemtoReg, PCSource, PCWr};

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zero(zero), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .PCSource(PCSource),
    .PCWr(PCWr), .state(state), .instr_cnt(instr_cnt)
  );

  mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .op(op), .funct(funct),
    .zero(zero), .ALUOp(a4), .ALUSrcA(s4),
    .ALUSrcB(b4), .ExtOp(e4), .IorD(i4),
    .MemWrite(m4), .IRWrite(ir4),
    .RegWrite(r4), .RegDst(d4),
    .MemtoReg(t4), .PCSource(p4),
    .PCWr(w4), .state(st4), .instr_cnt(cnt4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int unsigned mcnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  // Instruction-level model: which control steps an
  // instruction walks through and whether it retires.
  function automatic void path_of(
      input logic [5:0] o, input logic [5:0] f,
      output logic [7:0][3:0] p, output int n,
      output bit c);
    p = '1;
    p[0] = 4'd0;
    p[1] = 4'd1;
    n = 2;
    c = 1'b0;
    if (o == LW) begin
      p[2] = 4'd2; p[3] = 4'd3; p[4] = 4'd4;
      n = 5; c = 1'b1;
    end else if (o == SW) begin
      p[2] = 4'd2; p[3] = 4'd5; n = 4; c = 1'b1;
    end else if (o == RT) begin
      p[2] = 4'd6; n = 3;
      if (f == ADDU || f == SUBU) begin
        p[3] = 4'd7; n = 4; c = 1'b1;
      end
    end else if (o == ORI) begin
      p[2] = 4'd9; p[3] = 4'd10; n = 4; c = 1'b1;
    end else if (o == BEQ) begin
      p[2] = 4'd8; n = 3; c = 1'b1;
    end else if (o == JMP) begin
      p[2] = 4'd11; n = 3; c = 1'b1;
    end
  endfunction

  function automatic ctl_t exp_out(input logic [3:0] s,
                                   input logic [5:0] f,
                                   input logic z);
    ctl_t c;
    c = '0;
    case (s)
      4'd0: begin c.irw = 1; c.srcb = 2'b01; c.pcw = 1; end
      4'd1: begin c.srcb = 2'b11; c.ext = 1; end
      4'd2: begin c.srca = 1; c.srcb = 2'b10; c.ext = 1; end
      4'd3: c.iord = 1;
      4'd4: begin c.rw = 1; c.m2r = 1; end
      4'd5: begin c.iord = 1; c.mw = 1; end
      4'd6: begin
        c.srca = 1;
        c.aluop = (f == SUBU) ? 2'b01 : 2'b00;
      end
      4'd7: begin c.rw = 1; c.rd = 1; end
      4'd8: begin
        c.srca = 1; c.aluop = 2'b01; c.pcs = 2'b01; c.pcw = z;
      end
      4'd9: begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b10; end
      4'd10: c.rw = 1;
      4'd11: begin c.pcw = 1; c.pcs = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ctl", 32'(act), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    mcnt = 0;
    chk("rst_cnt", instr_cnt, 32'd0);
    chk("rst_cnt4", 32'(cnt4), 32'd0);
  endtask

  // Starts #1 after the edge entering FETCH; stops
  // when the DUT is back in FETCH or maxc cycles ran.
  task automatic run_instr(input logic [5:0] o,
                           input logic [5:0] f,
                           input logic z,
                           input int maxc,
                           output int lat);
    logic [7:0][3:0] p;
    int n;
    bit c;
    path_of(o, f, p, n, c);
    op = o;
    funct = f;
    zero = z;
    lat = 0;
    do begin
      @(negedge clk);
      chk("state", 32'(state), 32'(p[lat]));
      chk("ctl", 32'(act), 32'(exp_out(p[lat], f, z)));
      @(posedge clk);
      #1;
      lat++;
    end while (state != 4'd0 && lat < maxc && lat < 8);
    if (state == 4'd0) begin
      if (c) mcnt++;
      chk("cnt", instr_cnt, mcnt);
      chk("cnt4", 32'(cnt4), 32'(mcnt % 16));
    end
  endtask

  tv_t tv[10];
  int lat;
  int unsigned c0;

  initial begin
    tv[0] = '{"lw",      LW,  6'd0, 1'b0, 5, 1};
    tv[1] = '{"sw",      SW,  6'd0, 1'b0, 4, 1};
    tv[2] = '{"addu",    RT,  ADDU, 1'b0, 4, 1};
    tv[3] = '{"subu",    RT,  SUBU, 1'b0, 4, 1};
    tv[4] = '{"ori",     ORI, 6'd0, 1'b0, 4, 1};
    tv[5] = '{"beq_t",   BEQ, 6'd0, 1'b1, 3, 1};
    tv[6] = '{"beq_n",   BEQ, 6'd0, 1'b0, 3, 1};
    tv[7] = '{"j",       JMP, 6'd0, 1'b0, 3, 1};
    tv[8] = '{"bad_op",  6'b111111, 6'd0, 1'b0, 2, 0};
    tv[9] = '{"bad_fn",  RT,  6'd0, 1'b0, 3, 0};

    do_reset(2);

    for (int i = 0; i < 10; i++) begin
      c0 = instr_cnt;
      run_instr(tv[i].op, tv[i].fn, tv[i].z, 8, lat);
      chk({tv[i].name, "_lat"}, lat, tv[i].lat);
      chk({tv[i].name, "_inc"}, instr_cnt - c0, tv[i].inc);
    end

    // Reset in the middle of lw, two cycles long.
    run_instr(LW, 6'd0, 1'b0, 3, lat);
    chk("mid_lw_state", 32'(state), 32'd3);
    do_reset(2);
    @(negedge clk);
    chk("post_rst_irw", 32'(IRWrite), 32'd1);
    chk("post_rst_pcw", 32'(PCWr), 32'd1);
    @(posedge clk);
    #1;
    op = BEQ;
    @(negedge clk);
    @(posedge clk);
    #1;
    // BRANCH: PCWr must track zero within the cycle.
    zero = 1'b1;
    #1 chk("br_pcw_z1", 32'(PCWr), 32'd1);
    zero = 1'b0;
    #1 chk("br_pcw_z0", 32'(PCWr), 32'd0);
    zero = 1'b1;
    #1 chk("br_pcw_z1b", 32'(PCWr), 32'd1);
    @(posedge clk);
    #1;
    mcnt++;
    chk("br_cnt", instr_cnt, mcnt);
    chk("br_back", 32'(state), 32'd0);

    // Randomized instruction stream.
    for (int i = 0; i < 200; i++) begin
      logic [5:0] o, f;
      int k;
      k = $urandom_range(0, 9);
      f = 6'($urandom);
      case (k)
        0: o = LW;
        1: o = SW;
        2: begin o = RT; f = ADDU; end
        3: begin o = RT; f = SUBU; end
        4: o = RT;
        5: o = ORI;
        6: o = BEQ;
        7: o = JMP;
        default: o = 6'($urandom);
      endcase
      run_instr(o, f, 1'($urandom), 8, lat);
    end

    // 4-bit counter wraps after 16 retirements.
    do_reset(1);
    for (int i = 0; i < 16; i++)
      run_instr((i % 2 == 0) ? JMP : BEQ, 6'd0,
                1'($urandom), 8, lat);
    chk("wrap_cnt4", 32'(cnt4), 32'd0);
    chk("wrap_cnt", instr_cnt, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS datapath. It is the stage directly upstream of the ALU: it sequences each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the ALU operation code and operand selects, and the register-file, memory and PC enables. It consumes the ALU `Zero` flag to resolve `beq`. It also keeps a retired-instruction counter for simulation and debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `op`  in  6  opcode `IR[31:26]`; stable from DECODE onward (IR latched in FETCH).
- `funct`  in  6  `IR[5:0]`.
- `zero`  in  1  ALU `Zero` output (A == B).
- `ALUOp`  out  2  00 add, 01 sub, 10 or.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  00 = register B, 01 = constant 4, 10 = extended imm16, 11 = sign-ext imm16 << 2.
- `ExtOp`  out  1  1 = sign-extend imm16, 0 = zero-extend.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data memory write enable.
- `IRWrite`  out  1  instruction register load.
- `RegWrite`  out  1  register file write enable.
- `RegDst`  out  1  0 = rt, 1 = rd.
- `MemtoReg`  out  1  0 = ALUOut, 1 = MDR.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWr`  out  1  final PC write enable.
- `state`  out  4  current state encoding, for debug.
- `instr_cnt`  out  CNT_W  count of retired instructions.

## Operation
- The state register is 4 bits with encodings 0..11 as listed. Outputs are decoded from state (Moore), with two exceptions: `ALUOp` in EXEC depends on `funct`, and `PCWr` depends on `zero`. Any output not listed for a state is 0.
- FETCH (0): IRWrite = 1, ALUSrcB = 01, ALUOp = 00, PCWr = 1, PCSource = 00. Next state is DECODE.
- DECODE (1): ALUSrcB = 11, ExtOp = 1, ALUOp = 00 (the branch target is computed into ALUOut). Next state by `op`:
  - `100011` (lw) or `101011` (sw) → MEMADR.
  - `000000` → EXEC.
  - `001101` (ori) → ORIEX.
  - `000100` (beq) → BRANCH.
  - `000010` (j) → JUMP.
  - any other opcode → FETCH; no write occurs and the instruction is not counted.
- MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ExtOp = 1, ALUOp = 00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD (3): IorD = 1. Next is MEMWB.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0. Next is FETCH.
- MEMWR (5): IorD = 1, MemWrite = 1. Next is FETCH.
- EXEC (6): ALUSrcA = 1, ALUSrcB = 00. `funct` selects the path:
  - `100001` (addu): ALUOp = 00, next is RWB.
  - `100011` (subu): ALUOp = 01, next is RWB.
  - other funct: next is FETCH, nothing is written, the instruction is not counted.
- RWB (7): RegWrite = 1, RegDst = 1. Next is FETCH.
- BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 01, PCWr = `zero`. Next is FETCH.
- ORIEX (9): ALUSrcA = 1, ALUSrcB = 10, ExtOp = 0, ALUOp = 10. Next is ORIWB.
- ORIWB (10): RegWrite = 1, RegDst = 0. Next is FETCH.
- JUMP (11): PCWr = 1, PCSource = 10. Next is FETCH.
- Unused encodings 12–15 go to FETCH on the next edge, with all enables 0 while in them.
- `instr_cnt` increments by 1 on the clock edge that leaves MEMWB, MEMWR, RWB, BRANCH (taken or not), ORIWB or JUMP. It wraps modulo 2^CNT_W.

## Timing
- On a rising edge with `rst` = 1: state ← FETCH and `instr_cnt` ← 0.
- While `rst` is high, all enables (IRWrite, PCWr, RegWrite, MemWrite) and all mux selects/ALUOp are forced to 0. `state` reads 0.
- The first cycle after `rst` falls is FETCH.
- Reset asserted in any state, including mid-instruction, aborts the instruction with no further writes and no count.
- Instruction latency in cycles:
  - lw: 5.
  - sw, addu/subu, ori: 4.
  - beq, j: 3.
  - illegal opcode or funct: 2 or 3, with no count.
- `PCWr` in BRANCH follows `zero` combinationally within the same cycle.

## Test plan
- Reset: hold `rst` for 2 cycles in the middle of lw (state 3) → state = 0, `instr_cnt` = 0, all enables 0; the next cycle shows IRWrite = PCWr = 1.
- addu then subu:
  - `op` = 0, `funct` = 100001 → states 0, 1, 6, 7; ALUOp = 00 in EXEC; RegWrite = RegDst = 1 in RWB; `instr_cnt` = 1.
  - `funct` = 100011 → ALUOp = 01 in EXEC; `instr_cnt` = 2.
- lw then sw:
  - lw → states 0, 1, 2, 3, 4; IorD = 1 in MEMRD; MemtoReg = RegWrite = 1 in MEMWB.
  - sw → states 0, 1, 2, 5; MemWrite = 1 only in state 5.
- beq:
  - `zero` = 1 → in BRANCH, PCWr = 1, PCSource = 01, ALUOp = 01.
  - `zero` = 0 → PCWr = 0.
  - Both cases take 3 cycles and increment `instr_cnt`.
- ori and j:
  - ori → ORIEX has ALUOp = 10, ExtOp = 0; ORIWB has RegWrite = 1, RegDst = 0.
  - j → JUMP has PCWr = 1, PCSource = 10.
- Illegal and wrap:
  - `op` = 111111 → states 0, 1, 0; no writes, count unchanged.
  - `funct` = 000000 → states 0, 1, 6, 0.
  - With CNT_W = 4, 16 retired instructions → `instr_cnt` = 0.
